control_unit: RTL and testbench

// - Moore control sequencer for the Mini-SRC datapath. Runs fetch (T0-T2), then a per-opcode execute

---
 rtl/control_unit.sv | 183 ++++++++++++++++++
 tb/tb_control_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Moore control sequencer for the Mini-SRC datapath: fetch T0-T2, then per-opcode execute T3-T6.
// Optional MEM_WAIT_EN: T1 stretches until MemReady, adding the MemReady port.
module control_unit #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OP_W   = 5
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [WORD_W-1:0] IR,
    input  logic              Stop,
`ifdef MEM_WAIT_EN
    input  logic              MemReady,
`endif
    output logic              PCout,
    output logic              PCin,
    output logic              IncPC,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              Read,
    output logic              IRin,
    output logic              Yin,
    output logic              ZHighin,
    output logic              ZLowin,
    output logic              ZHighout,
    output logic              ZLowout,
    output logic              HIin,
    output logic              LOin,
    output logic              Cout,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic [OP_W-1:0]   OP,
    output logic              Run,
    output logic              IllegalOp,
    output logic [3:0]        State
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        C_RALU, C_IMM, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILL
    } class_e;

    state_e          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] imm_op;
    class_e          cls;
    state_e          final_next;
    logic            unused_ir;

    // Ra/Rb/Rc fields are consumed by the datapath's register-select logic, not here
    assign opcode    = IR[WORD_W-1 -: OP_W];
    assign unused_ir = ^IR[WORD_W-OP_W-1:0];

    always_comb begin
        cls = C_ILL;
        if (opcode >= OP_W'(3) && opcode <= OP_W'(11))       cls = C_RALU;
        else if (opcode >= OP_W'(12) && opcode <= OP_W'(14)) cls = C_IMM;
        else if (opcode == OP_W'(15) || opcode == OP_W'(16)) cls = C_MULDIV;
        else if (opcode == OP_W'(17) || opcode == OP_W'(18)) cls = C_UNARY;
        else if (opcode == OP_W'(26))                        cls = C_NOP;
        else if (opcode == OP_W'(27))                        cls = C_HALT;
    end

    // Immediate forms reuse the register ALU ops: addi->add, andi->and, ori->or
    always_comb begin
        case (opcode)
            OP_W'(12): imm_op = OP_W'(3);
            OP_W'(13): imm_op = OP_W'(5);
            default:   imm_op = OP_W'(6);
        endcase
    end

    assign final_next = Stop ? S_HALT : S_T0;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q   <= S_RESET;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; Read = 1'b0; IRin = 1'b0; Yin = 1'b0; ZHighin = 1'b0;
        ZLowin = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; HIin = 1'b0; LOin = 1'b0;
        Cout = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        OP = '0;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                ZLowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
`ifdef MEM_WAIT_EN
                // PC update only on the exit cycle so it is written exactly once
                PCin = MemReady;
                if (MemReady) state_d = S_T2;
`else
                PCin = 1'b1;
                state_d = S_T2;
`endif
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                case (cls)
                    C_NOP:  state_d = final_next;
                    C_HALT: state_d = S_HALT;
                    C_ILL: begin
                        state_d   = final_next;
                        illegal_d = 1'b1;
                    end
                    default: state_d = S_T3;
                endcase
            end
            S_T3: begin
                state_d = S_T4;
                case (cls)
                    C_RALU, C_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_MULDIV:      begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_UNARY: begin
                        Grb = 1'b1; Rout = 1'b1; ZLowin = 1'b1; OP = opcode;
                    end
                    default: state_d = S_T0;
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (cls)
                    C_RALU: begin Grc = 1'b1; Rout = 1'b1; ZLowin = 1'b1; OP = opcode; end
                    C_IMM:  begin Cout = 1'b1; ZLowin = 1'b1; OP = imm_op; end
                    C_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; ZHighin = 1'b1; ZLowin = 1'b1; OP = opcode;
                    end
                    C_UNARY: begin
                        ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        state_d = final_next;
                    end
                    default: state_d = S_T0;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_RALU, C_IMM: begin
                        ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        state_d = final_next;
                    end
                    C_MULDIV: begin ZLowout = 1'b1; LOin = 1'b1; state_d = S_T6; end
                    default:  state_d = S_T0;
                endcase
            end
            S_T6: begin
                if (cls == C_MULDIV) begin
                    ZHighout = 1'b1; HIin = 1'b1;
                    state_d = final_next;
                end else begin
                    state_d = S_T0;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    assign Run       = (state_q != S_RESET) && (state_q != S_HALT);
    assign IllegalOp = illegal_q;
    assign State     = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected control vectors are queued, then popped and compared.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        Stop;
`ifdef MEM_WAIT_EN
    logic        MemReady;
`endif
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic Yin, ZHighin, ZLowin, ZHighout, ZLowout, HIin, LOin, Cout;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [4:0] OP;
    logic Run, IllegalOp;
    logic [3:0] State;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
`ifdef MEM_WAIT_EN
        .MemReady(MemReady),
`endif
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .ZHighin(ZHighin),
        .ZLowin(ZLowin), .ZHighout(ZHighout), .ZLowout(ZLowout), .HIin(HIin),
        .LOin(LOin), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .OP(OP), .Run(Run), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 Clock = ~Clock;

    localparam logic [3:0] ST_RESET = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                           ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7,
                           ST_HALT = 4'd8;

    localparam logic [20:0] M_PCOUT = 21'(1) << 20, M_PCIN = 21'(1) << 19,
        M_INCPC = 21'(1) << 18, M_MARIN = 21'(1) << 17, M_MDRIN = 21'(1) << 16,
        M_MDROUT = 21'(1) << 15, M_READ = 21'(1) << 14, M_IRIN = 21'(1) << 13,
        M_YIN = 21'(1) << 12, M_ZHIN = 21'(1) << 11, M_ZLIN = 21'(1) << 10,
        M_ZHOUT = 21'(1) << 9, M_ZLOUT = 21'(1) << 8, M_HIIN = 21'(1) << 7,
        M_LOIN = 21'(1) << 6, M_COUT = 21'(1) << 5, M_GRA = 21'(1) << 4,
        M_GRB = 21'(1) << 3, M_GRC = 21'(1) << 2, M_RIN = 21'(1) << 1, M_ROUT = 21'(1);

    logic [20:0] ctrl;
    assign ctrl = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, ZHighin,
                   ZLowin, ZHighout, ZLowout, HIin, LOin, Cout, Gra, Grb, Grc, Rin, Rout};

    typedef struct {
        string       tag;
        logic [31:0] ir;
        logic        stop;
        logic        mrdy;
        logic [3:0]  st;
        logic [20:0] ctrl;
        logic [4:0]  op;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic m_ill  = 1'b0;

    task automatic push(input string tag, input logic [31:0] ir, input logic stop,
                        input logic mrdy, input logic [3:0] st, input logic [20:0] c,
                        input logic [4:0] op);
        exp_t e;
        e.tag = tag; e.ir = ir; e.stop = stop; e.mrdy = mrdy;
        e.st = st; e.ctrl = c; e.op = op; e.ill = m_ill;
        q.push_back(e);
    endtask

    task automatic check_entry(input exp_t e);
        logic exp_run;
        exp_run = (e.st != ST_RESET) && (e.st != ST_HALT);
        checks++;
        assert (State === e.st) else begin
            errors++; $error("FAIL %s state got %0d exp %0d", e.tag, State, e.st);
        end
        checks++;
        assert (ctrl === e.ctrl) else begin
            errors++; $error("FAIL %s ctrl got %06h exp %06h", e.tag, ctrl, e.ctrl);
        end
        checks++;
        assert (OP === e.op) else begin
            errors++; $error("FAIL %s op got %05b exp %05b", e.tag, OP, e.op);
        end
        checks++;
        assert (Run === exp_run) else begin
            errors++; $error("FAIL %s run got %b exp %b", e.tag, Run, exp_run);
        end
        checks++;
        assert (IllegalOp === e.ill) else begin
            errors++; $error("FAIL %s illegal got %b exp %b", e.tag, IllegalOp, e.ill);
        end
    endtask

    // Drive each queued cycle's inputs, compare on the falling edge, advance one clock
    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            IR = e.ir; Stop = e.stop;
`ifdef MEM_WAIT_EN
            MemReady = e.mrdy;
`endif
            @(negedge Clock);
            check_entry(e);
            @(posedge Clock); #1;
        end
    endtask

    task automatic push_fetch(input string tag, input logic [31:0] ir, input logic stop2,
                              input int waits);
        push({tag, "_t0"}, ir, 1'b0, 1'b1, ST_T0, M_PCOUT | M_MARIN | M_INCPC | M_ZLIN, 5'd0);
`ifdef MEM_WAIT_EN
        for (int i = 0; i < waits; i++)
            push({tag, "_t1w"}, ir, 1'b0, 1'b0, ST_T1, M_ZLOUT | M_READ | M_MDRIN, 5'd0);
`endif
        push({tag, "_t1"}, ir, 1'b0, 1'b1, ST_T1, M_ZLOUT | M_PCIN | M_READ | M_MDRIN, 5'd0);
        push({tag, "_t2"}, ir, stop2, 1'b1, ST_T2, M_MDROUT | M_IRIN, 5'd0);
    endtask

    task automatic push_ralu(input string tag, input logic [31:0] ir, input logic [4:0] op,
                             input logic stop, input int waits);
        push_fetch(tag, ir, 1'b0, waits);
        push({tag, "_t3"}, ir, 1'b0, 1'b1, ST_T3, M_GRB | M_ROUT | M_YIN, 5'd0);
        push({tag, "_t4"}, ir, 1'b0, 1'b1, ST_T4, M_GRC | M_ROUT | M_ZLIN, op);
        push({tag, "_t5"}, ir, stop, 1'b1, ST_T5, M_ZLOUT | M_GRA | M_RIN, 5'd0);
    endtask

    task automatic push_halted(input string tag, input int n);
        for (int i = 0; i < n; i++)
            push(tag, 32'hD800_0000, 1'b0, 1'b1, ST_HALT, 21'd0, 5'd0);
    endtask

    // Async clear from mid-cycle: outputs must drop immediately, before any clock edge
    task automatic pulse_clear(input string tag);
        exp_t e;
        Clear = 1'b1;
        #2;
        m_ill = 1'b0;
        e.tag = tag; e.ir = IR; e.stop = 1'b0; e.mrdy = 1'b1;
        e.st = ST_RESET; e.ctrl = 21'd0; e.op = 5'd0; e.ill = 1'b0;
        check_entry(e);
        Clear = 1'b0;
        @(posedge Clock); #1;
    endtask

    initial begin
        Clear = 1'b1; IR = 32'd0; Stop = 1'b0;
`ifdef MEM_WAIT_EN
        MemReady = 1'b1;
`endif
        @(posedge Clock); #1;
        push("rst_hold", 32'd0, 1'b0, 1'b1, ST_RESET, 21'd0, 5'd0);
        push("rst_hold", 32'd0, 1'b0, 1'b1, ST_RESET, 21'd0, 5'd0);
        drain();
        Clear = 1'b0;
        push("rst_rel", 32'd0, 1'b0, 1'b1, ST_RESET, 21'd0, 5'd0);
        drain();

        push_ralu("shra", 32'h409A_8000, 5'b01000, 1'b0, 0);
        drain();

        push_fetch("mul", 32'h78A0_0000, 1'b0, 0);
        push("mul_t3", 32'h78A0_0000, 1'b0, 1'b1, ST_T3, M_GRA | M_ROUT | M_YIN, 5'd0);
        push("mul_t4", 32'h78A0_0000, 1'b0, 1'b1, ST_T4, M_GRB | M_ROUT | M_ZHIN | M_ZLIN, 5'b01111);
        push("mul_t5", 32'h78A0_0000, 1'b0, 1'b1, ST_T5, M_ZLOUT | M_LOIN, 5'd0);
        push("mul_t6", 32'h78A0_0000, 1'b0, 1'b1, ST_T6, M_ZHOUT | M_HIIN, 5'd0);
        drain();

        push_fetch("addi", 32'h6088_0005, 1'b0, 0);
        push("addi_t3", 32'h6088_0005, 1'b0, 1'b1, ST_T3, M_GRB | M_ROUT | M_YIN, 5'd0);
        push("addi_t4", 32'h6088_0005, 1'b0, 1'b1, ST_T4, M_COUT | M_ZLIN, 5'b00011);
        push("addi_t5", 32'h6088_0005, 1'b0, 1'b1, ST_T5, M_ZLOUT | M_GRA | M_RIN, 5'd0);
        push_fetch("ori", 32'h7000_0000, 1'b0, 0);
        push("ori_t3", 32'h7000_0000, 1'b0, 1'b1, ST_T3, M_GRB | M_ROUT | M_YIN, 5'd0);
        push("ori_t4", 32'h7000_0000, 1'b0, 1'b1, ST_T4, M_COUT | M_ZLIN, 5'b00110);
        push("ori_t5", 32'h7000_0000, 1'b0, 1'b1, ST_T5, M_ZLOUT | M_GRA | M_RIN, 5'd0);
        drain();

        push_fetch("neg", 32'h8800_0000, 1'b0, 0);
        push("neg_t3", 32'h8800_0000, 1'b0, 1'b1, ST_T3, M_GRB | M_ROUT | M_ZLIN, 5'b10001);
        push("neg_t4", 32'h8800_0000, 1'b0, 1'b1, ST_T4, M_ZLOUT | M_GRA | M_RIN, 5'd0);
        push_fetch("nop", 32'hD000_0000, 1'b0, 0);
        drain();

        // Illegal opcode behaves as nop; the flag rises on the T2 edge and stays up
        push_fetch("ill", 32'hF800_0000, 1'b0, 0);
        drain();
        m_ill = 1'b1;
        push_fetch("abort", 32'h409A_8000, 1'b0, 0);
        push("abort_t3", 32'h409A_8000, 1'b0, 1'b1, ST_T3, M_GRB | M_ROUT | M_YIN, 5'd0);
        drain();
        push("abort_t4", 32'h409A_8000, 1'b0, 1'b1, ST_T4, M_GRC | M_ROUT | M_ZLIN, 5'b01000);
        check_entry(q.pop_front());
        pulse_clear("clear_mid_t4");

`ifdef MEM_WAIT_EN
        push_ralu("memwait", 32'h409A_8000, 5'b01000, 1'b0, 3);
        drain();
`endif

        push_ralu("stop", 32'h409A_8000, 5'b01000, 1'b1, 0);
        push_halted("stop_halt", 3);
        drain();
        pulse_clear("clear_halt");

        push_fetch("halt", 32'hD800_0000, 1'b0, 0);
        push_halted("halt_hold", 20);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
